// File: rtl/sine_dds_multi.sv
// sine_dds_multi: time-multiplexed multi-channel quadrature DDS.
// One shared sin/cos pipeline serves CHANNELS round-robin phase accumulators.
// Ports:
//   clk, rst           clock, async active-high reset
//   cfg_*              per-channel step/offset write (valid/ready)
//   phase_sync         pulse: zero every accumulator
//   output_sample_*    AXI-stream I (cos) / Q (sin), tid = channel,
//                      tlast on channel CHANNELS-1
// Option: define SINE_DDS_DITHER_EN to add LFSR phase dither
// ahead of the LUT truncation.
module sine_dds_multi #(
  parameter int CHANNELS     = 4,
  parameter int PHASE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int LUT_WIDTH    = 10,
  parameter int CH_WIDTH     =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_WIDTH-1:0]     cfg_channel,
  input  logic [PHASE_WIDTH-1:0]  cfg_step,
  input  logic [PHASE_WIDTH-1:0]  cfg_offset,
  input  logic                    cfg_tvalid,
  output logic                    cfg_tready,
  input  logic                    phase_sync,
  output logic [OUTPUT_WIDTH-1:0] output_sample_i_tdata,
  output logic [OUTPUT_WIDTH-1:0] output_sample_q_tdata,
  output logic [CH_WIDTH-1:0]     output_sample_tid,
  output logic                    output_sample_tlast,
  output logic                    output_sample_tvalid,
  input  logic                    output_sample_tready
);

  localparam int PW = PHASE_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int LW = LUT_WIDTH;
  localparam int AW = LW - 2;
  localparam int N  = 1 << AW;
  localparam int A  = (1 << (OW - 1)) - 1;
  localparam logic [CH_WIDTH-1:0] LAST =
    CH_WIDTH'(CHANNELS - 1);

  // Quarter-wave table: entry k = round(A*sin(2pi(k+0.5)/2^LW)).
  // Taylor series keeps the elaboration free of math builtins.
  function automatic logic [N*OW-1:0] gen_rom();
    logic [N*OW-1:0] r;
    real x;
    real t;
    real s;
    int  v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      x = 2.0 * 3.14159265358979323846
        * (real'(k) + 0.5) / real'(4 * N);
      s = x;
      t = x;
      for (int j = 1; j < 14; j++) begin
        t = -t * x * x / real'((2 * j) * (2 * j + 1));
        s = s + t;
      end
      v = $rtoi(s * real'(A) + 0.5);
      r[k*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  localparam logic [N*OW-1:0] ROM = gen_rom();

  logic [OW-1:0] w_rom [N];
  for (genvar k = 0; k < N; k++) begin : g_rom
    assign w_rom[k] = ROM[k*OW +: OW];
  end

  logic [PW-1:0]       r_acc  [CHANNELS];
  logic [PW-1:0]       r_step [CHANNELS];
  logic [PW-1:0]       r_off  [CHANNELS];
  logic                r_cfg_rdy;
  logic                r_s0_v;
  logic [CH_WIDTH-1:0] r_ptr;
  logic                r_s1_v;
  logic [CH_WIDTH-1:0] r_s1_ch;
  logic [LW-1:0]       r_s1_p;
  logic                r_s2_v;
  logic [CH_WIDTH-1:0] r_s2_ch;
  logic [AW-1:0]       r_s2_ia;
  logic [AW-1:0]       r_s2_qa;
  logic                r_s2_ni;
  logic                r_s2_nq;
  logic                r_s3_v;
  logic [CH_WIDTH-1:0] r_s3_ch;
  logic [OW-1:0]       r_s3_i;
  logic [OW-1:0]       r_s3_q;
  logic                r_s3_ni;
  logic                r_s3_nq;
  logic                r_o_v;
  logic [CH_WIDTH-1:0] r_o_ch;
  logic                r_o_last;
  logic [OW-1:0]       r_o_i;
  logic [OW-1:0]       r_o_q;

  logic          w_en;
  logic          w_issue;
  logic          w_cfg_wr;
  logic [PW-1:0] w_dith;
  logic [PW-1:0] w_phase;
  logic          w_unused_lsb;
  logic [1:0]    w_quad;
  logic [AW-1:0] w_idx;
  logic [OW-1:0] w_i_sgn;
  logic [OW-1:0] w_q_sgn;

  assign w_en     = !(r_o_v && !output_sample_tready);
  assign w_issue  = w_en && r_s0_v;
  assign w_cfg_wr = cfg_tvalid && r_cfg_rdy;

`ifdef SINE_DDS_DITHER_EN
  localparam int DW = (PW - LW > 16) ? 16 : (PW - LW);
  logic [15:0] r_lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_en) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]}
              ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_dith = PW'(r_lfsr[15 -: DW]) << (PW - LW - DW);
`else
  assign w_dith = '0;
`endif

  assign w_phase = r_acc[r_ptr] + r_off[r_ptr] + w_dith;
  assign w_unused_lsb = ^w_phase[PW-LW-1:0];

  // Fold: I = cos, Q = sin; cos(x) reads the mirrored index ~i.
  assign w_quad = r_s1_p[LW-1 -: 2];
  assign w_idx  = r_s1_p[AW-1:0];

  assign w_i_sgn = r_s3_ni ? (OW'(0) - r_s3_i) : r_s3_i;
  assign w_q_sgn = r_s3_nq ? (OW'(0) - r_s3_q) : r_s3_q;

  // Sync overrides the issue increment; config lands after
  // this edge's issue so the issuing sample sees old values.
  // Out-of-range cfg_channel never matches any c.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]  <= '0;
        r_step[c] <= '0;
        r_off[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (phase_sync) begin
          r_acc[c] <= '0;
        end else if (w_issue &&
                     r_ptr == CH_WIDTH'(c)) begin
          r_acc[c] <= r_acc[c] + r_step[c];
        end
        if (w_cfg_wr &&
            cfg_channel == CH_WIDTH'(c)) begin
          r_step[c] <= cfg_step;
          r_off[c]  <= cfg_offset;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_rdy <= 1'b0;
      r_s0_v    <= 1'b0;
      r_ptr     <= '0;
      r_s1_v    <= 1'b0;
      r_s1_ch   <= '0;
      r_s1_p    <= '0;
      r_s2_v    <= 1'b0;
      r_s2_ch   <= '0;
      r_s2_ia   <= '0;
      r_s2_qa   <= '0;
      r_s2_ni   <= 1'b0;
      r_s2_nq   <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s3_ch   <= '0;
      r_s3_i    <= '0;
      r_s3_q    <= '0;
      r_s3_ni   <= 1'b0;
      r_s3_nq   <= 1'b0;
      r_o_v     <= 1'b0;
      r_o_ch    <= '0;
      r_o_last  <= 1'b0;
      r_o_i     <= '0;
      r_o_q     <= '0;
    end else begin
      r_cfg_rdy <= 1'b1;
      if (w_en) begin
        r_s0_v <= 1'b1;
        if (r_s0_v) begin
          r_ptr <= (r_ptr == LAST)
                 ? '0 : r_ptr + CH_WIDTH'(1);
        end
        r_s1_v  <= r_s0_v;
        r_s1_ch <= r_ptr;
        r_s1_p  <= w_phase[PW-1 -: LW];
        r_s2_v  <= r_s1_v;
        r_s2_ch <= r_s1_ch;
        r_s2_ia <= w_quad[0] ? w_idx : ~w_idx;
        r_s2_qa <= w_quad[0] ? ~w_idx : w_idx;
        r_s2_ni <= ^w_quad;
        r_s2_nq <= w_quad[1];
        r_s3_v  <= r_s2_v;
        r_s3_ch <= r_s2_ch;
        r_s3_i  <= w_rom[r_s2_ia];
        r_s3_q  <= w_rom[r_s2_qa];
        r_s3_ni <= r_s2_ni;
        r_s3_nq <= r_s2_nq;
        r_o_v    <= r_s3_v;
        r_o_ch   <= r_s3_ch;
        r_o_last <= (r_s3_ch == LAST);
        r_o_i    <= w_i_sgn;
        r_o_q    <= w_q_sgn;
      end
    end
  end

  assign cfg_tready            = r_cfg_rdy;
  assign output_sample_i_tdata = r_o_i;
  assign output_sample_q_tdata = r_o_q;
  assign output_sample_tid     = r_o_ch;
  assign output_sample_tlast   = r_o_last;
  assign output_sample_tvalid  = r_o_v;

endmodule

// File: tb/tb_sine_dds_multi.sv
// tb_sine_dds_multi: directed + random stimulus for sine_dds_multi,
// checked against a transaction-level sample model.
module tb_sine_dds_multi;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_channel = '0;
  logic [31:0] cfg_step = '0;
  logic [31:0] cfg_offset = '0;
  logic        cfg_tvalid = 1'b0;
  logic        cfg_tready;
  logic        phase_sync = 1'b0;
  logic [15:0] o_i;
  logic [15:0] o_q;
  logic [1:0]  o_tid;
  logic        o_tlast;
  logic        o_tvalid;
  logic        tready = 1'b1;

  always #5 clk = ~clk;

  sine_dds_multi #(
    .CHANNELS(CH), .PHASE_WIDTH(32),
    .OUTPUT_WIDTH(16), .LUT_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_channel(cfg_channel),
    .cfg_step(cfg_step),
    .cfg_offset(cfg_offset),
    .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready),
    .phase_sync(phase_sync),
    .output_sample_i_tdata(o_i),
    .output_sample_q_tdata(o_q),
    .output_sample_tid(o_tid),
    .output_sample_tlast(o_tlast),
    .output_sample_tvalid(o_tvalid),
    .output_sample_tready(tready)
  );

  typedef struct {
    int i;
    int q;
    int id;
  } smp_t;

  smp_t        expq[$];
  logic [31:0] mph [CH];
  logic [31:0] mstep [CH];
  logic [31:0] moff [CH];
  int          nen;
  bit          mrdy;
  bit          mv;
  int          errs = 0;
  int          checks = 0;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Ideal lookup: angle of the centre of the LUT cell.
  function automatic smp_t look(logic [31:0] ph, int id);
    smp_t s;
    int   p;
    real  a;
    p = int'(ph >> 22);
    a = 2.0 * 3.14159265358979323846
      * (real'(p) + 0.5) / 1024.0;
    s.i  = rnd(32767.0 * $cos(a));
    s.q  = rnd(32767.0 * $sin(a));
    s.id = id;
    return s;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    nen  = 0;
    mrdy = 1'b0;
    mv   = 1'b0;
    expq.delete();
    for (int c = 0; c < CH; c++) begin
      mph[c]   = '0;
      mstep[c] = '0;
      moff[c]  = '0;
    end
  endtask

  task automatic check_out();
    chk("cfg_tready", {31'b0, cfg_tready}, {31'b0, mrdy});
    chk("tvalid", {31'b0, o_tvalid}, {31'b0, mv});
    if (mv) begin
      if (expq.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL queue: got empty expected sample");
      end else begin
        chk("i", {{16{o_i[15]}}, o_i}, expq[0].i);
        chk("q", {{16{o_q[15]}}, o_q}, expq[0].q);
        chk("tid", {30'b0, o_tid}, expq[0].id);
        chk("tlast", {31'b0, o_tlast},
            (expq[0].id == CH - 1) ? 1 : 0);
      end
    end
  endtask

  // One clock: drive, step the model at the edge, check at negedge.
  // Sample k issues on the (k+2)th enabled edge; tvalid follows
  // the fifth enabled edge and never drops afterwards.
  task automatic tick(input bit rdy, input bit cv,
                      input logic [1:0] cc,
                      input logic [31:0] cs,
                      input logic [31:0] co,
                      input bit sy);
    bit en;
    int c;
    tready      = rdy;
    cfg_tvalid  = cv;
    cfg_channel = cc;
    cfg_step    = cs;
    cfg_offset  = co;
    phase_sync  = sy;
    @(posedge clk);
    en = !(mv && !rdy);
    if (mv && rdy) void'(expq.pop_front());
    if (en) begin
      if (nen >= 1) begin
        c = (nen - 1) % CH;
        expq.push_back(look(mph[c] + moff[c], c));
        mph[c] = mph[c] + mstep[c];
      end
      nen++;
    end
    if (cv && mrdy) begin
      mstep[cc] = cs;
      moff[cc]  = co;
    end
    if (sy) begin
      for (int k = 0; k < CH; k++) mph[k] = '0;
    end
    mrdy = 1'b1;
    mv   = (nen >= 5);
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int n, input bit rand_rdy);
    for (int k = 0; k < n; k++) begin
      tick(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1,
           1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tvalid", {31'b0, o_tvalid}, 0);
    chk("rst_cfg_tready", {31'b0, cfg_tready}, 0);
    chk("rst_i", {16'b0, o_i}, 0);
    chk("rst_q", {16'b0, o_q}, 0);
    chk("rst_tid", {30'b0, o_tid}, 0);
    chk("rst_tlast", {31'b0, o_tlast}, 0);
    cfg_tvalid = 1'b0;
    phase_sync = 1'b0;
    tready     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic quarter_setup();
    idle(1, 1'b0);
    tick(1'b1, 1'b1, 2'd0, 32'h4000_0000, 32'd0, 1'b0);
    tick(1'b1, 1'b1, 2'd2, 32'd0, 32'h8000_0000, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    quarter_setup();
    idle(40, 1'b0);

    // Hold tready low, then release.
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    end
    idle(12, 1'b0);
    idle(120, 1'b1);

    // Write ch0 in the very cycle ch0 issues.
    while (((nen - 1) % CH) != 0) idle(1, 1'b0);
    tick(1'b1, 1'b1, 2'd0, 32'h2000_0000, 32'd0, 1'b0);
    idle(24, 1'b0);

    // Sync pulse, then each channel restarts at its offset.
    tick(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    idle(16, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
    idle(16, 1'b1);

    // Random config, sync and backpressure.
    for (int k = 0; k < 300; k++) begin
      tick(1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)),
           $urandom, $urandom,
           ($urandom_range(0, 24) == 0));
    end
    idle(10, 1'b0);

    // Mid-stream reset, then the power-up sequence again.
    #2;
    do_reset();
    quarter_setup();
    idle(30, 1'b0);
    idle(40, 1'b1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
